// File: rtl/cs_fifoc2cs.sv
// rtl/cs_fifoc2cs.sv - FIFO C command-frame responder for the fs/fd_fifoc2cs handshake.
// Optional: define CS_CHKSUM_EN to verify the XOR checksum byte.
module cs_fifoc2cs #(
  parameter logic [7:0] HEAD_BYTE = 8'h55,
  parameter int         MAX_LEN   = 16,
  parameter int         ADDR_W    = 4,
  parameter int         TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_fifoc2cs,
  output logic              fd_fifoc2cs,
  input  logic              fifoc_empty,
  output logic              fifoc_rd_en,
  input  logic [7:0]        fifoc_dout,
  output logic [7:0]        cmd_code,
  output logic [7:0]        cmd_len,
  output logic              cmd_valid,
  output logic              cmd_err,
  output logic              cfg_wr_en,
  output logic [ADDR_W-1:0] cfg_wr_addr,
  output logic [7:0]        cfg_wr_data
);

  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_HEAD, S_CMD, S_LEN, S_DATA, S_CSUM, S_WRITE, S_ERR, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic              r_rd_pend;
  logic [7:0]        r_code, r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [TW-1:0]     r_tmo;
  logic [7:0]        r_cmd_code, r_cmd_len;
  logic              r_cmd_valid, r_cmd_err;
  logic [7:0]        r_buf [MAX_LEN];
  logic              w_fetch, w_cap, w_tmo, w_abort, w_last, w_csum_ok, w_start;

`ifdef CS_CHKSUM_EN
  logic [7:0] r_acc;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_acc <= '0;
    else if (w_start) r_acc <= '0;
    else if (w_cap && r_state == S_CMD) r_acc <= fifoc_dout;
    else if (w_cap && (r_state == S_LEN || r_state == S_DATA)) r_acc <= r_acc ^ fifoc_dout;
  end
  assign w_csum_ok = (fifoc_dout == r_acc);
`else
  assign w_csum_ok = 1'b1;
`endif

  assign w_start     = (r_state == S_IDLE) && fs_fifoc2cs;
  assign w_fetch     = (r_state == S_HEAD) || (r_state == S_CMD) || (r_state == S_LEN) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_abort     = !fs_fifoc2cs && (r_state != S_IDLE) && (r_state != S_DONE);
  assign fifoc_rd_en = w_fetch && fs_fifoc2cs && !fifoc_empty && !r_rd_pend;
  assign w_cap       = w_fetch && fs_fifoc2cs && r_rd_pend;
  assign w_tmo       = w_fetch && !r_rd_pend && fifoc_empty && (r_tmo == TMO);
  assign w_last      = (8'(r_idx) == r_len - 8'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (fs_fifoc2cs) w_next = S_HEAD;
      S_HEAD:  if (w_cap && fifoc_dout == HEAD_BYTE) w_next = S_CMD;
      S_CMD:   if (w_cap) w_next = S_LEN;
      S_LEN:   if (w_cap) begin
                 if (fifoc_dout > MAX_LEN8)    w_next = S_ERR;
                 else if (fifoc_dout == 8'd0) w_next = S_CSUM;
                 else                         w_next = S_DATA;
               end
      S_DATA:  if (w_cap && w_last) w_next = S_CSUM;
      S_CSUM:  if (w_cap) w_next = !w_csum_ok ? S_ERR : (r_len == 8'd0) ? S_DONE : S_WRITE;
      S_WRITE: if (w_last) w_next = S_DONE;
      S_ERR:   w_next = S_DONE;
      S_DONE:  if (!fs_fifoc2cs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo)   w_next = S_DONE;
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rd_pend   <= 1'b0;
      r_code      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_cmd_code  <= '0;
      r_cmd_len   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rd_pend   <= fifoc_rd_en;
      r_cmd_valid <= 1'b0;
      if (w_start) begin
        r_cmd_err <= 1'b0;
        r_idx     <= '0;
      end
      // Idle-with-empty counter; any captured byte restarts it.
      if (w_start || w_cap) r_tmo <= '0;
      else if (w_fetch && fifoc_empty && !r_rd_pend && r_tmo != TMO) r_tmo <= r_tmo + 1'b1;
      if (w_tmo) r_cmd_err <= 1'b1;
      if (!w_abort) begin
        case (r_state)
          S_CMD:   if (w_cap) r_code <= fifoc_dout;
          S_LEN:   if (w_cap) begin
                     r_len <= fifoc_dout;
                     r_idx <= '0;
                   end
          S_DATA:  if (w_cap) r_idx <= w_last ? '0 : r_idx + 1'b1;
          S_CSUM:  if (w_cap && w_csum_ok && r_len == 8'd0) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_code  <= r_code;
                     r_cmd_len   <= r_len;
                   end
          S_WRITE: if (w_last) begin
                     r_cmd_valid <= 1'b1;
                     r_cmd_code  <= r_code;
                     r_cmd_len   <= r_len;
                   end else begin
                     r_idx <= r_idx + 1'b1;
                   end
          S_ERR:   r_cmd_err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Payload buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && w_cap) r_buf[r_idx] <= fifoc_dout;
  end

  assign fd_fifoc2cs = (r_state == S_DONE);
  assign cfg_wr_en   = (r_state == S_WRITE) && fs_fifoc2cs;
  assign cfg_wr_addr = cfg_wr_en ? r_idx : '0;
  assign cfg_wr_data = cfg_wr_en ? r_buf[r_idx] : 8'd0;
  assign cmd_code    = r_cmd_code;
  assign cmd_len     = r_cmd_len;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_err     = r_cmd_err;

endmodule
